// File: rtl/hdc_pkg.sv
// rtl/hdc_pkg.sv - shared hypervector geometry constants and types
package hdc_pkg;

    // HV_DIM must be an exact multiple of DIMS_PER_CC.
    localparam int HV_DIM      = 5000;
    localparam int DIMS_PER_CC = 500;
    localparam int NUM_CHUNKS  = HV_DIM / DIMS_PER_CC;
    localparam int CTR_W       = $clog2(NUM_CHUNKS);

    typedef logic [HV_DIM-1:0]      hv_t;
    typedef logic [DIMS_PER_CC-1:0] chunk_t;

endpackage

// File: rtl/hv_chunk_mux.sv
// rtl/hv_chunk_mux.sv - combinational chunk selector over a full hypervector
//
// Ports:
//   hv_i    full hypervector
//   idx_i   chunk index
//   chunk_o hv_i[idx_i*DIMS_PER_CC +: DIMS_PER_CC], zero for out-of-range idx_i
module hv_chunk_mux
    import hdc_pkg::*;
(
    input  hv_t              hv_i,
    input  logic [CTR_W-1:0] idx_i,
    output chunk_t           chunk_o
);

    // Explicit compare-and-select keeps out-of-range indices (idx_i = NUM_CHUNKS
    // when the top asks for the slice after the last one) at a defined zero.
    always_comb begin
        chunk_o = '0;
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            if (idx_i == CTR_W'(i)) begin
                chunk_o = hv_i[i*DIMS_PER_CC +: DIMS_PER_CC];
            end
        end
    end

endmodule

// File: rtl/hv_chunk_streamer.sv
// rtl/hv_chunk_streamer.sv - streams a captured hypervector out as NUM_CHUNKS registered slices
//
// Ports:
//   clk, nrst                 clock, asynchronous active-low reset
//   flush                     synchronous abort back to IDLE (no done pulse)
//   load_valid/load_ready     capture handshake for encoded_hv
//   encoded_hv                full hypervector to stream
//   chunk_valid/chunk_ready   output slice handshake
//   chunk_data                registered current slice (lowest first)
//   chunk_idx, chunk_last     index of current slice, high on final slice
//   busy                      streaming in progress
//   done                      one-cycle pulse after the final slice is accepted
module hv_chunk_streamer
    import hdc_pkg::*;
(
    input  logic             clk,
    input  logic             nrst,
    input  logic             flush,
    input  logic             load_valid,
    output logic             load_ready,
    input  hv_t              encoded_hv,
    output logic             chunk_valid,
    input  logic             chunk_ready,
    output chunk_t           chunk_data,
    output logic [CTR_W-1:0] chunk_idx,
    output logic             chunk_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    localparam logic [CTR_W-1:0] LAST_IDX = CTR_W'(NUM_CHUNKS - 1);

    state_e           state_q, state_d;
    logic [CTR_W-1:0] ctr_q, ctr_d;
    hv_t              shadow_q, shadow_d;
    chunk_t           data_q, data_d;
    logic             done_q, done_d;

    logic [CTR_W-1:0] next_idx;
    chunk_t           next_chunk;
    chunk_t           first_chunk;

    assign next_idx = ctr_q + CTR_W'(1);

    // Slice following the current one, taken from the shadow copy.
    hv_chunk_mux u_next_mux (
        .hv_i    (shadow_q),
        .idx_i   (next_idx),
        .chunk_o (next_chunk)
    );

    // Slice 0 straight from the input so the first chunk is registered at capture.
    hv_chunk_mux u_first_mux (
        .hv_i    (encoded_hv),
        .idx_i   ('0),
        .chunk_o (first_chunk)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= ST_IDLE;
            ctr_q    <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctr_q    <= ctr_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ctr_d    = ctr_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        done_d   = 1'b0;

        if (flush) begin
            // Shadow and chunk_data are kept; only the stream position is dropped.
            state_d = ST_IDLE;
            ctr_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_valid) begin
                        shadow_d = encoded_hv;
                        data_d   = first_chunk;
                        ctr_d    = '0;
                        state_d  = ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (ctr_q > LAST_IDX) begin
                        // Counter outside the legal range: recover to IDLE.
                        state_d = ST_IDLE;
                        ctr_d   = '0;
                    end else if (chunk_ready) begin
                        if (ctr_q == LAST_IDX) begin
                            state_d = ST_IDLE;
                            ctr_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            ctr_d  = next_idx;
                            data_d = next_chunk;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    ctr_d   = '0;
                end
            endcase
        end
    end

    assign chunk_valid = (state_q == ST_SEND);
    assign busy        = (state_q == ST_SEND);
    // Held low while reset is asserted so no load is offered before release.
    assign load_ready  = (state_q == ST_IDLE) && nrst;
    assign chunk_data  = data_q;
    assign chunk_idx   = ctr_q;
    assign chunk_last  = (state_q == ST_SEND) && (ctr_q == LAST_IDX);
    assign done        = done_q;

endmodule

// File: tb/tb_hv_chunk_streamer.sv
// tb/tb_hv_chunk_streamer.sv - self-checking bench for hv_chunk_streamer
module tb_hv_chunk_streamer;
    import hdc_pkg::*;

    logic             clk;
    logic             nrst;
    logic             flush;
    logic             load_valid;
    logic             load_ready;
    hv_t              encoded_hv;
    logic             chunk_valid;
    logic             chunk_ready;
    chunk_t           chunk_data;
    logic [CTR_W-1:0] chunk_idx;
    logic             chunk_last;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_errors = 0;

    hv_chunk_streamer dut (
        .clk         (clk),
        .nrst        (nrst),
        .flush       (flush),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .encoded_hv  (encoded_hv),
        .chunk_valid (chunk_valid),
        .chunk_ready (chunk_ready),
        .chunk_data  (chunk_data),
        .chunk_idx   (chunk_idx),
        .chunk_last  (chunk_last),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_w(input string name, input chunk_t act, input chunk_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Chunk k: every bit equals k[0], low byte tagged with k, next byte with salt.
    function automatic chunk_t make_chunk(input int k, input logic [7:0] salt);
        chunk_t c;
        c = {DIMS_PER_CC{k[0]}};
        c[7:0]  = k[7:0];
        c[15:8] = salt;
        return c;
    endfunction

    function automatic hv_t make_hv(input logic [7:0] salt);
        hv_t h;
        for (int k = 0; k < NUM_CHUNKS; k++) h[k*DIMS_PER_CC +: DIMS_PER_CC] = make_chunk(k, salt);
        return h;
    endfunction

    // Transaction-level model: a queue of slices still owed to the consumer.
    typedef struct {
        chunk_t data;
        int     idx;
    } exp_t;

    exp_t exp_q[$];
    bit   exp_done;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            exp_q.delete();
            exp_done = 1'b0;
        end else begin
            bit d;
            d = 1'b0;
            if (flush) begin
                exp_q.delete();
            end else if (exp_q.size() != 0) begin
                if (chunk_ready) begin
                    if (exp_q.size() == 1) d = 1'b1;
                    void'(exp_q.pop_front());
                end
            end else if (load_valid) begin
                for (int k = 0; k < NUM_CHUNKS; k++) begin
                    exp_t e;
                    e.data = encoded_hv[k*DIMS_PER_CC +: DIMS_PER_CC];
                    e.idx  = k;
                    exp_q.push_back(e);
                end
            end
            exp_done = d;
        end
    end

    always @(negedge clk) begin
        if (nrst) begin
            bit v;
            v = (exp_q.size() != 0);
            check("chunk_valid", int'(chunk_valid), int'(v));
            check("busy", int'(busy), int'(v));
            check("load_ready", int'(load_ready), int'(!v));
            check("done", int'(done), int'(exp_done));
            if (v) begin
                check("chunk_idx", int'(chunk_idx), exp_q[0].idx);
                check("chunk_last", int'(chunk_last), int'(exp_q[0].idx == NUM_CHUNKS - 1));
                check_w("chunk_data", chunk_data, exp_q[0].data);
            end else begin
                check("chunk_last_idle", int'(chunk_last), 0);
            end
        end
    end

    // Starts at a negedge; returns at the negedge where done is seen.
    task automatic stream(input hv_t hv, input int stall_at, input int stall_len,
                          input int intrude_at, input hv_t other, input bit pin,
                          output int cycles);
        int stalls;
        encoded_hv  = hv;
        load_valid  = 1'b1;
        chunk_ready = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        cycles = 0;
        stalls = stall_len;
        while (!done && cycles < 200) begin
            chunk_ready = 1'b1;
            load_valid  = 1'b0;
            if (chunk_valid && int'(chunk_idx) == stall_at && stalls > 0) begin
                chunk_ready = 1'b0;
                stalls--;
            end
            if (chunk_valid && int'(chunk_idx) == intrude_at) begin
                load_valid = 1'b1;
                encoded_hv = other;
            end
            if (pin && chunk_valid && chunk_idx == 3) begin
                check("pin_idx3_tag", int'(chunk_data[7:0]), 3);
                check("pin_idx3_msb", int'(chunk_data[DIMS_PER_CC-1]), 1);
                check("pin_idx3_last", int'(chunk_last), 0);
            end
            if (pin && chunk_valid && chunk_idx == 9) begin
                check("pin_idx9_tag", int'(chunk_data[7:0]), 9);
                check("pin_idx9_last", int'(chunk_last), 1);
            end
            @(negedge clk);
            cycles++;
        end
        load_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL stream_timeout: no done within %0d cycles", cycles);
        end
    endtask

    task automatic wait_idx(input int idx);
        int n;
        n = 0;
        while (!(chunk_valid && int'(chunk_idx) == idx) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reach_idx", int'(chunk_idx), idx);
    endtask

    initial begin
        int c1;
        int c2;
        nrst        = 1'b0;
        flush       = 1'b0;
        load_valid  = 1'b0;
        chunk_ready = 1'b1;
        encoded_hv  = '0;

        #3;
        check("rst_valid", int'(chunk_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_idx", int'(chunk_idx), 0);
        check("rst_last", int'(chunk_last), 0);
        check_w("rst_data", chunk_data, '0);
        @(negedge clk);
        @(negedge clk);
        #1 nrst = 1'b1;
        @(negedge clk);
        check("post_rst_load_ready", int'(load_ready), 1);

        // Basic stream
        stream(make_hv(8'h11), -1, 0, -1, '0, 1'b1, c1);
        check("basic_cycles", c1, 10);
        check("basic_done_load_ready", int'(load_ready), 1);
        @(negedge clk);

        // Backpressure at idx 4
        stream(make_hv(8'h22), 4, 3, -1, '0, 1'b0, c1);
        check("bp_cycles", c1, 13);
        @(negedge clk);

        // Load while busy at idx 2
        stream(make_hv(8'h33), -1, 0, 2, make_hv(8'hEE), 1'b0, c1);
        check("intrude_cycles", c1, 10);
        @(negedge clk);

        // Flush at idx 6
        encoded_hv = make_hv(8'h44);
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        wait_idx(6);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_valid", int'(chunk_valid), 0);
        check("flush_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        // Flush together with load in IDLE drops the load
        flush      = 1'b1;
        load_valid = 1'b1;
        encoded_hv = make_hv(8'h55);
        @(negedge clk);
        flush      = 1'b0;
        load_valid = 1'b0;
        check("flush_load_dropped", int'(chunk_valid), 0);
        stream(make_hv(8'h66), -1, 0, -1, '0, 1'b0, c1);
        check("post_flush_cycles", c1, 10);
        @(negedge clk);

        // Async reset at idx 3
        encoded_hv = make_hv(8'h77);
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        wait_idx(3);
        #2 nrst = 1'b0;
        #1;
        check("arst_valid", int'(chunk_valid), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_idx", int'(chunk_idx), 0);
        check("arst_done", int'(done), 0);
        check_w("arst_data", chunk_data, '0);
        @(negedge clk);
        @(negedge clk);
        #1 nrst = 1'b1;
        @(negedge clk);
        check("arst_rel_load_ready", int'(load_ready), 1);
        check("arst_rel_done", int'(done), 0);
        @(negedge clk);

        // Back-to-back
        stream(make_hv(8'h88), -1, 0, -1, '0, 1'b0, c1);
        stream(make_hv(8'h99), -1, 0, -1, '0, 1'b0, c2);
        check("b2b_cycles", c1 + 1 + c2, 21);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hv_chunk_streamer.md
Name: hv_chunk_streamer

Overview:
- Reads a fully assembled encoded hypervector and streams it out as NUM_CHUNKS consecutive DIMS_PER_CC-bit slices.
- Slices are emitted lowest first, under valid/ready flow control.
- Sits between the encoder output register and downstream chunk-serial consumers (associative memory search, class-HV training accumulator).
- Mirrors the encoder's chunk-per-cycle assembly in the opposite direction.

Parameters:
- HV_DIM, 5000, hypervector width in bits
- DIMS_PER_CC, 500, bits per chunk; HV_DIM must be an exact multiple of DIMS_PER_CC
- NUM_CHUNKS, HV_DIM/DIMS_PER_CC (10), chunks per hypervector
- CTR_W, $clog2(NUM_CHUNKS) (4), chunk index width

Ports:
- clk  input  1  clock
- nrst  input  1  reset, asynchronous, active-low
- flush  input  1  synchronous abort; returns the block to IDLE
- load_valid  input  1  encoded_hv is valid for capture
- load_ready  output  1  block can accept a new hypervector
- encoded_hv  input  HV_DIM  full hypervector to stream
- chunk_valid  output  1  chunk_data is valid
- chunk_ready  input  1  consumer accepts the current chunk
- chunk_data  output  DIMS_PER_CC  current slice
- chunk_idx  output  CTR_W  index of the current slice
- chunk_last  output  1  current slice is index NUM_CHUNKS-1
- busy  output  1  streaming in progress
- done  output  1  one-cycle pulse after the last chunk is accepted

Behaviour:
- Reset (nrst low, asynchronous):
  - state=IDLE; shadow register=0; ctr=0.
  - chunk_data=0, chunk_idx=0, chunk_valid=0, chunk_last=0, busy=0, done=0.
  - load_ready=1 once reset is released.
- FSM states: IDLE, SEND.
- IDLE:
  - load_ready=1, chunk_valid=0, busy=0.
  - On load_valid: capture encoded_hv into the shadow register, ctr<=0, chunk_data<=encoded_hv[DIMS_PER_CC-1:0], go to SEND.
  - Capture-to-first-valid latency is 1 cycle.
- SEND:
  - chunk_valid=1, busy=1, load_ready=0.
  - chunk_idx=ctr.
  - chunk_last=(ctr==NUM_CHUNKS-1).
- Handshake: a transfer occurs when chunk_valid && chunk_ready.
  - Non-last transfer: ctr<=ctr+1; chunk_data<=shadow[(ctr+1)*DIMS_PER_CC +: DIMS_PER_CC].
  - Last transfer: ctr<=0, go to IDLE, done<=1 for exactly one cycle.
- Backpressure: while chunk_ready=0, chunk_data, chunk_idx and chunk_last hold and chunk_valid stays 1. chunk_valid never deasserts without a transfer, except on flush or reset.
- chunk_data is registered; there is no combinational path from encoded_hv or chunk_ready to chunk_data.
- Throughput: 1 chunk/cycle with chunk_ready held high. A full HV takes NUM_CHUNKS cycles in SEND.
- Back-to-back operation:
  - In the cycle done=1, the block is already in IDLE with load_ready=1.
  - A load in that cycle starts the next HV, so the gap between HVs is 1 idle cycle.
- load_valid while in SEND is ignored; the shadow register is not overwritten.
- Flush:
  - Has priority over the handshake and over load.
  - Next state is IDLE; ctr=0; chunk_valid=0; done is not pulsed; the shadow register is retained.
  - flush in IDLE together with load_valid: the load is dropped.
- Reset asserted mid-stream: all outputs return to reset values immediately. No done pulse follows reset release.
- ctr never exceeds NUM_CHUNKS-1; the unreachable state decodes to IDLE.

Decomposition:
- Shared package hdc_pkg holds: HV_DIM, DIMS_PER_CC, NUM_CHUNKS, CTR_W, and typedef hv_t / chunk_t.
- The encoder output register switches to the same constants.
- FSM state enum lives locally in the module.
- One natural sub-module: hv_chunk_mux, a combinational shadow[idx*DIMS_PER_CC +: DIMS_PER_CC] selector. The block instantiates it with idx=ctr+1 for the next slice and idx=0 for the capture path.

Test Plan:
- Basic stream: load HV whose chunk k is all bits = k[0] with word tag k, chunk_ready=1 -> chunks 0..9 on 10 consecutive cycles; chunk_last only at idx 9; done=1 on the following cycle; load_ready=1 in that same cycle.
- Backpressure: chunk_ready=0 for 3 cycles at idx 4 -> chunk_data/idx frozen at slice 4, chunk_valid=1 throughout; stream resumes with idx 5; total 13 cycles to done.
- Load while busy: second load_valid with a different HV at idx 2 -> ignored; remaining chunks 3..9 come from the first HV; load_ready=0 until done.
- Flush at idx 6 -> next cycle chunk_valid=0, busy=0, no done pulse; a new load then streams from idx 0 correctly.
- Async reset at idx 3 -> outputs zero immediately with no clock edge; after release load_ready=1 and no done pulse.
- Back-to-back: load HV A, then load HV B in A's done cycle -> B idx 0 valid on the next cycle; 21 cycles total for 20 chunks.
